// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | mem_arb_pkg : shared sizing defaults and lock-table entry type           |
// | Revision    : 1.0                                                        |
// +-------------------------------------------------------------------------+
package mem_arb_pkg;

  localparam int C_DEF   = 8;
  localparam int LAW_DEF = 10;
  // Lock addresses are stored zero-extended to this width; LAW must not exceed it.
  localparam int LAW_MAX = 16;

  typedef struct packed {
    logic               held;
    logic [LAW_MAX-1:0] adr;
  } lock_entry_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | rr_pick : first set request at or after the pointer, ascending modulo N  |
// | Revision: 1.0                                                            |
// +-------------------------------------------------------------------------+
module rr_pick #(
  parameter int N  = 8,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic          o_valid,
  output logic [IW-1:0] o_idx
);

  // Scan offsets from farthest to nearest so the nearest requester wins last.
  always_comb begin : p_pick
    int j;
    j       = 0;
    o_valid = 1'b0;
    o_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(i_ptr) + k;
      if (j >= N) j = j - N;
      if (i_req[j]) begin
        o_valid = 1'b1;
        o_idx   = IW'(j);
      end
    end
  end

  assign o_gnt = o_valid ? (N'(1) << o_idx) : '0;

endmodule
`default_nettype wire

// File: rtl/mem_lock_arbiter.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | mem_lock_arbiter : round-robin main-memory arbiter plus address lock table |
// | Revision         : 1.0                                                    |
// +-------------------------------------------------------------------------+
module mem_lock_arbiter
  import mem_arb_pkg::*;
#(
  parameter int C   = C_DEF,
  parameter int LAW = LAW_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [C-1:0]          i_rd_req,
  input  logic [C-1:0]          i_wr_req,
  input  logic [C-1:0][15:0]    i_rd_adr,
  input  logic [C-1:0][15:0]    i_wr_adr,
  input  logic [C-1:0][15:0]    i_wr_dat,
  output logic [C-1:0]          o_main_mem_ac,
  output logic                  o_mem_read,
  output logic                  o_mem_write,
  output logic [15:0]           o_mem_read_adr,
  output logic [15:0]           o_mem_write_adr,
  output logic [15:0]           o_mem_write_dat,
  input  logic [C-1:0]          i_lock_en,
  input  logic [C-1:0]          i_unlock_en,
  input  logic [C-1:0][LAW-1:0] i_lock_adr,
  output logic [C-1:0]          o_lock_ac,
  output logic [31:0]           o_contention
);

  localparam int IW = (C > 1) ? $clog2(C) : 1;

  logic [IW-1:0]         r_mptr;
  logic [IW-1:0]         r_lptr;
  lock_entry_t [C-1:0]   r_lock;
  logic [C-1:0]          r_lock_ac;
  logic [31:0]           r_contention;

  logic [C-1:0]          w_mem_req;
  logic [C-1:0]          w_mem_gnt;
  logic                  w_mem_vld;
  logic [IW-1:0]         w_mem_idx;
  logic                  w_mem_multi;
  logic [C-1:0]          w_lock_elig;
  logic [C-1:0]          w_lock_gnt;
  logic                  w_lock_vld;
  logic [IW-1:0]         w_lock_idx;

  function automatic logic [IW-1:0] f_inc(input logic [IW-1:0] idx);
    return (int'(idx) == C - 1) ? '0 : idx + 1'b1;
  endfunction

  assign w_mem_req   = i_rd_req | i_wr_req;
  assign w_mem_multi = (w_mem_req & (w_mem_req - 1'b1)) != '0;

  rr_pick #(.N(C), .IW(IW)) u_mem_pick (
    .i_req   (w_mem_req),
    .i_ptr   (r_mptr),
    .o_gnt   (w_mem_gnt),
    .o_valid (w_mem_vld),
    .o_idx   (w_mem_idx)
  );

  assign o_main_mem_ac   = w_mem_gnt;
  assign o_mem_read      = w_mem_vld & i_rd_req[w_mem_idx];
  assign o_mem_write     = w_mem_vld & i_wr_req[w_mem_idx];
  assign o_mem_read_adr  = w_mem_vld ? i_rd_adr[w_mem_idx] : 16'h0000;
  assign o_mem_write_adr = w_mem_vld ? i_wr_adr[w_mem_idx] : 16'h0000;
  assign o_mem_write_dat = w_mem_vld ? i_wr_dat[w_mem_idx] : 16'h0000;

  // A holder that is unlocking this cycle still blocks its address.
  always_comb begin
    w_lock_elig = '0;
    for (int i = 0; i < C; i++) begin
      w_lock_elig[i] = i_lock_en[i] & ~r_lock[i].held & ~i_unlock_en[i];
      for (int j = 0; j < C; j++) begin
        if (r_lock[j].held && (r_lock[j].adr == LAW_MAX'(i_lock_adr[i])))
          w_lock_elig[i] = 1'b0;
      end
    end
  end

  rr_pick #(.N(C), .IW(IW)) u_lock_pick (
    .i_req   (w_lock_elig),
    .i_ptr   (r_lptr),
    .o_gnt   (w_lock_gnt),
    .o_valid (w_lock_vld),
    .o_idx   (w_lock_idx)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_mptr       <= '0;
      r_contention <= '0;
    end else begin
      if (w_mem_vld)
        r_mptr <= f_inc(w_mem_idx);
      if (w_mem_multi && (r_contention != 32'hFFFF_FFFF))
        r_contention <= r_contention + 32'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_lptr    <= '0;
      r_lock    <= '0;
      r_lock_ac <= '0;
    end else begin
      r_lock_ac <= w_lock_gnt;
      for (int i = 0; i < C; i++) begin
        if (i_unlock_en[i])
          r_lock[i].held <= 1'b0;
      end
      if (w_lock_vld) begin
        r_lptr                   <= f_inc(w_lock_idx);
        r_lock[w_lock_idx].held  <= 1'b1;
        r_lock[w_lock_idx].adr   <= LAW_MAX'(i_lock_adr[w_lock_idx]);
      end
    end
  end

  assign o_lock_ac    = r_lock_ac;
  assign o_contention = r_contention;

endmodule
`default_nettype wire
